// File: rtl/cp0_regfile_param.sv
`default_nettype none
// ============================================================================
// Module   : cp0_regfile_param
// Purpose  : Coprocessor-0 register file (BadVAddr, Count, Compare, Status,
//            Cause, EPC) with a prescaled Count timer, a configurable number
//            of hardware interrupt lines and nested-exception handling.
//            It also produces the masked interrupt request for the
//            exception stage.
// Ports    : clk, reset (sync, active-low)
//            we_i/waddr_i/wdata_i    - MTC0 write port (write-back stage)
//            raddr_i/rdata_o         - MFC0 combinational read port
//            int_i                   - external interrupt levels
//            exc_*_i, eret_i         - exception / ERET commit (MEM stage)
//            status_o/cause_o/epc_o  - architectural register views
//            int_req_o, timer_int_o  - interrupt request, sticky timer flag
// Revision : 1.0 - initial release
// ============================================================================
module cp0_regfile_param #(
    parameter int COUNT_DIV    = 2,    // core cycles per Count increment, 1..256
    parameter int HW_INT_NUM   = 6,    // external interrupt lines, 1..6
    parameter bit TIMER_ON_IP7 = 1'b1  // OR timer flag into Cause.IP[7]
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [4:0]            raddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [HW_INT_NUM-1:0] int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  exc_in_delayslot_i,
    input  logic [31:0]           exc_badvaddr_i,
    input  logic                  eret_i,
    output logic [31:0]           rdata_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic                  int_req_o,
    output logic                  timer_int_o
);

    localparam logic [4:0] c_addr_badvaddr = 5'd8;
    localparam logic [4:0] c_addr_count    = 5'd9;
    localparam logic [4:0] c_addr_compare  = 5'd11;
    localparam logic [4:0] c_addr_status   = 5'd12;
    localparam logic [4:0] c_addr_cause    = 5'd13;
    localparam logic [4:0] c_addr_epc      = 5'd14;
    localparam logic [4:0] c_exc_adel      = 5'd4;
    localparam logic [4:0] c_exc_ades      = 5'd5;
    localparam logic [7:0] c_presc_max     = 8'(COUNT_DIV - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q,    count_d;
    logic [7:0]  presc_q,    presc_d;
    logic [31:0] compare_q,  compare_d;
    logic [7:0]  im_q,       im_d;
    logic        exl_q,      exl_d;
    logic        ie_q,       ie_d;
    logic        bd_q,       bd_d;
    logic        ti_q,       ti_d;
    logic [1:0]  ip_sw_q,    ip_sw_d;
    logic [5:0]  ip_hw_q,    ip_hw_d;   // Cause.IP[15:10] as sampled from int_i
    logic [4:0]  exccode_q,  exccode_d;
    logic [31:0] epc_q,      epc_d;

    logic        w_wr_count, w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc;
    logic        w_match;
    logic [5:0]  w_int_ext;
    logic        w_ip7;
    logic [7:0]  w_cause_ip;

    assign w_wr_count   = we_i && (waddr_i == c_addr_count);
    assign w_wr_compare = we_i && (waddr_i == c_addr_compare);
    assign w_wr_status  = we_i && (waddr_i == c_addr_status);
    assign w_wr_cause   = we_i && (waddr_i == c_addr_cause);
    assign w_wr_epc     = we_i && (waddr_i == c_addr_epc);

    // Narrow interrupt buses are zero-extended so unused IP bits read 0.
    generate
        if (HW_INT_NUM < 6) begin : g_int_pad
            assign w_int_ext = {{(6 - HW_INT_NUM){1'b0}}, int_i};
        end else begin : g_int_full
            assign w_int_ext = int_i;
        end
    endgenerate

    generate
        if (TIMER_ON_IP7) begin : g_timer_ip7
            assign w_ip7 = ip_hw_q[5] | ti_q;
        end else begin : g_no_timer_ip7
            assign w_ip7 = ip_hw_q[5];
        end
    endgenerate

    assign w_cause_ip = {w_ip7, ip_hw_q[4:0], ip_sw_q};

    // The match is taken on next-state values so the sticky flag rises on
    // the same edge that Count reaches Compare.
    assign w_match = (compare_d != 32'd0) && (count_d == compare_d);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        presc_d    = presc_q;
        compare_d  = compare_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        ip_sw_d    = ip_sw_q;
        ip_hw_d    = w_int_ext;
        exccode_d  = exccode_q;
        epc_d      = epc_q;

        // Count: a software write restarts the prescaler and beats the tick.
        if (w_wr_count) begin
            count_d = wdata_i;
            presc_d = 8'd0;
        end else if (presc_q == c_presc_max) begin
            count_d = count_q + 32'd1;
            presc_d = 8'd0;
        end else begin
            presc_d = presc_q + 8'd1;
        end

        if (w_wr_compare) begin
            compare_d = wdata_i;
        end

        // Compare write acknowledges the timer and wins over a fresh match.
        if (w_wr_compare) begin
            ti_d = 1'b0;
        end else if (w_match) begin
            ti_d = 1'b1;
        end

        // MTC0 lands first; exception/ERET below override only what they own.
        if (w_wr_status) begin
            im_d  = wdata_i[15:8];
            exl_d = wdata_i[1];
            ie_d  = wdata_i[0];
        end
        if (w_wr_cause) begin
            ip_sw_d = wdata_i[9:8];
        end
        if (w_wr_epc) begin
            epc_d = wdata_i;
        end

        if (exc_valid_i) begin
            // EPC/BD are frozen while already inside a handler.
            if (!exl_q) begin
                epc_d = exc_in_delayslot_i ? (exc_pc_i - 32'd4) : exc_pc_i;
                bd_d  = exc_in_delayslot_i;
            end
            exccode_d = exc_code_i;
            exl_d     = 1'b1;
            if ((exc_code_i == c_exc_adel) || (exc_code_i == c_exc_ades)) begin
                badvaddr_d = exc_badvaddr_i;
            end
        end else if (eret_i) begin
            exl_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            badvaddr_q <= 32'd0;
            count_q    <= 32'd0;
            presc_q    <= 8'd0;
            compare_q  <= 32'd0;
            im_q       <= 8'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_sw_q    <= 2'd0;
            ip_hw_q    <= 6'd0;
            exccode_q  <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            compare_q  <= compare_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ip_hw_d;
            exccode_q  <= exccode_d;
            epc_q      <= epc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // BEV (bit 22) is hard-wired to 1.
    assign status_o    = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_o     = {bd_q, ti_q, 14'd0, w_cause_ip, 1'b0, exccode_q, 2'b00};
    assign epc_o       = epc_q;
    assign timer_int_o = ti_q;
    assign int_req_o   = ie_q & ~exl_q & (|(im_q & w_cause_ip));

    always_comb begin
        rdata_o = 32'd0;
        case (raddr_i)
            c_addr_badvaddr: rdata_o = badvaddr_q;
            c_addr_count:    rdata_o = count_q;
            c_addr_compare:  rdata_o = compare_q;
            c_addr_status:   rdata_o = status_o;
            c_addr_cause:    rdata_o = cause_o;
            c_addr_epc:      rdata_o = epc_q;
            default:         rdata_o = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_regfile_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_regfile_param
// Purpose  : Self-checking bench for cp0_regfile_param. The main instance
//            (COUNT_DIV=4, 6 interrupt lines, timer on IP7) is tracked by a
//            behavioural model; a second instance (COUNT_DIV=1, 3 lines,
//            timer not on IP7) covers the alternate parameter set.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cp0_regfile_param;

    localparam int DIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT stimulus / observation
    logic        reset;
    logic        we;
    logic [4:0]  waddr, raddr;
    logic [31:0] wdata;
    logic [5:0]  int_in;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_ds;
    logic [31:0] exc_badv;
    logic        eret;
    logic [31:0] rdata, status, cause, epc;
    logic        int_req, timer_int;

    // Secondary DUT
    logic        u1_reset;
    logic        u1_we;
    logic [4:0]  u1_waddr, u1_raddr;
    logic [31:0] u1_wdata;
    logic [2:0]  u1_int;
    logic [31:0] u1_rdata, u1_status, u1_cause, u1_epc;
    logic        u1_int_req, u1_timer;

    int n_checks = 0;
    int n_fail   = 0;

    cp0_regfile_param #(.COUNT_DIV(DIV), .HW_INT_NUM(6), .TIMER_ON_IP7(1'b1)) u_dut (
        .clk(clk), .reset(reset), .we_i(we), .waddr_i(waddr), .raddr_i(raddr),
        .wdata_i(wdata), .int_i(int_in), .exc_valid_i(exc_valid),
        .exc_code_i(exc_code), .exc_pc_i(exc_pc), .exc_in_delayslot_i(exc_ds),
        .exc_badvaddr_i(exc_badv), .eret_i(eret), .rdata_o(rdata),
        .status_o(status), .cause_o(cause), .epc_o(epc),
        .int_req_o(int_req), .timer_int_o(timer_int)
    );

    cp0_regfile_param #(.COUNT_DIV(1), .HW_INT_NUM(3), .TIMER_ON_IP7(1'b0)) u_dut1 (
        .clk(clk), .reset(u1_reset), .we_i(u1_we), .waddr_i(u1_waddr),
        .raddr_i(u1_raddr), .wdata_i(u1_wdata), .int_i(u1_int),
        .exc_valid_i(1'b0), .exc_code_i(5'd0), .exc_pc_i(32'd0),
        .exc_in_delayslot_i(1'b0), .exc_badvaddr_i(32'd0), .eret_i(1'b0),
        .rdata_o(u1_rdata), .status_o(u1_status), .cause_o(u1_cause),
        .epc_o(u1_epc), .int_req_o(u1_int_req), .timer_int_o(u1_timer)
    );

    // ------------------------------------------------------------------
    // Reference model of the main instance. Count is kept as "value last
    // written + elapsed cycles / DIV" rather than as a prescaler.
    // ------------------------------------------------------------------
    logic [31:0] m_badv, m_cnt_base, m_compare, m_epc;
    int          m_cnt_cyc;
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_ipext;
    logic [4:0]  m_exc;

    function automatic logic [31:0] m_count();
        return m_cnt_base + 32'(m_cnt_cyc / DIV);
    endfunction
    function automatic logic [7:0] m_ip();
        return {m_ipext[5] | m_ti, m_ipext[4:0], m_ipsw};
    endfunction
    function automatic logic [31:0] m_status();
        return 32'h0040_0000 | {16'd0, m_im, 6'd0, m_exl, m_ie};
    endfunction
    function automatic logic [31:0] m_cause();
        return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_exc, 2'b00};
    endfunction
    function automatic logic m_intreq();
        return m_ie & ~m_exl & (|(m_im & m_ip()));
    endfunction
    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count();
            5'd11:   return m_compare;
            5'd12:   return m_status();
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock: model next state from current inputs, then edge.
    task automatic cycle();
        logic [31:0] n_badv, n_base, n_cmp, n_epc, n_cnt;
        int          n_cyc;
        logic [7:0]  n_im;
        logic        n_exl, n_ie, n_bd, n_ti;
        logic [1:0]  n_ipsw;
        logic [4:0]  n_exc;
        n_badv = m_badv; n_base = m_cnt_base; n_cmp = m_compare; n_epc = m_epc;
        n_cyc = m_cnt_cyc; n_im = m_im; n_exl = m_exl; n_ie = m_ie; n_bd = m_bd;
        n_ti = m_ti; n_ipsw = m_ipsw; n_exc = m_exc;
        if (!reset) begin
            n_badv = 0; n_base = 0; n_cyc = 0; n_cmp = 0; n_epc = 0; n_im = 0;
            n_exl = 0; n_ie = 0; n_bd = 0; n_ti = 0; n_ipsw = 0; n_exc = 0;
        end else begin
            if (we && waddr == 5'd9) begin n_base = wdata; n_cyc = 0; end
            else n_cyc = m_cnt_cyc + 1;
            if (we && waddr == 5'd11) n_cmp = wdata;
            n_cnt = n_base + 32'(n_cyc / DIV);
            if (we && waddr == 5'd11) n_ti = 1'b0;
            else if (n_cmp != 0 && n_cnt == n_cmp) n_ti = 1'b1;
            if (we && waddr == 5'd12) begin
                n_im = wdata[15:8]; n_exl = wdata[1]; n_ie = wdata[0];
            end
            if (we && waddr == 5'd13) n_ipsw = wdata[9:8];
            if (we && waddr == 5'd14) n_epc = wdata;
            if (exc_valid) begin
                if (!m_exl) begin
                    n_epc = exc_ds ? exc_pc - 32'd4 : exc_pc;
                    n_bd  = exc_ds;
                end
                n_exc = exc_code;
                n_exl = 1'b1;
                if (exc_code == 5'd4 || exc_code == 5'd5) n_badv = exc_badv;
            end else if (eret) begin
                n_exl = 1'b0;
            end
        end
        @(posedge clk);
        m_badv = n_badv; m_cnt_base = n_base; m_cnt_cyc = n_cyc; m_compare = n_cmp;
        m_epc = n_epc; m_im = n_im; m_exl = n_exl; m_ie = n_ie; m_bd = n_bd;
        m_ti = n_ti; m_ipsw = n_ipsw; m_exc = n_exc;
        m_ipext = reset ? int_in : 6'd0;
        #1;
    endtask

    task automatic drive_idle();
        we = 1'b0; exc_valid = 1'b0; eret = 1'b0; exc_ds = 1'b0;
        u1_we = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0; u1_reset = 1'b0;
        cycle(); cycle();
        for (int a = 0; a < 32; a++) begin
            logic [31:0] exp;
            raddr = 5'(a);
            exp = (a == 12) ? 32'h0040_0000 : 32'd0;
            #1;
            n_checks++;
            if (rdata !== exp) begin
                n_fail++;
                $display("FAIL reset_read addr=%0d got=%h exp=%h", a, rdata, exp);
            end
        end
        n_checks++;
        if (int_req !== 1'b0 || timer_int !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq got int_req=%b timer=%b exp=0/0", int_req, timer_int);
        end
        reset = 1'b1;
    endtask

    task automatic test_timer();
        bit hit;
        we = 1'b1; waddr = 5'd9; wdata = 32'h10; cycle(); drive_idle();
        repeat (12) cycle();
        raddr = 5'd9; #1;
        n_checks++;
        if (rdata !== 32'h13) begin
            n_fail++; $display("FAIL timer_count got=%h exp=00000013", rdata);
        end
        we = 1'b1; waddr = 5'd11; wdata = 32'h14; cycle(); drive_idle();
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            cycle();
            raddr = 5'd9; #1;
            if (rdata == 32'h14) hit = 1'b1;
            else begin
                n_checks++;
                if (timer_int !== 1'b0) begin
                    n_fail++; $display("FAIL timer_early count=%h timer=%b exp=0", rdata, timer_int);
                end
            end
        end
        n_checks++;
        if (!hit || timer_int !== 1'b1 || cause[30] !== 1'b1 || cause[15] !== 1'b1) begin
            n_fail++;
            $display("FAIL timer_match hit=%b timer=%b cause=%h exp timer=1 bits30,15=1", hit, timer_int, cause);
        end
        we = 1'b1; waddr = 5'd11; wdata = 32'h100; cycle(); drive_idle();
        n_checks++;
        if (timer_int !== 1'b0 || cause[30] !== 1'b0 || cause[15] !== 1'b0) begin
            n_fail++; $display("FAIL timer_clear timer=%b cause=%h exp cleared", timer_int, cause);
        end
    endtask

    task automatic test_interrupt();
        we = 1'b1; waddr = 5'd12; wdata = 32'h0000_FF01; cycle(); drive_idle();
        n_checks++;
        if (status !== 32'h0040_FF01 || int_req !== 1'b0) begin
            n_fail++; $display("FAIL irq_status status=%h int_req=%b exp 0040ff01/0", status, int_req);
        end
        int_in = 6'b000100; cycle();
        n_checks++;
        if (cause[12] !== 1'b1 || int_req !== 1'b1) begin
            n_fail++; $display("FAIL irq_pending cause=%h int_req=%b exp bit12=1 int_req=1", cause, int_req);
        end
        exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h100; exc_ds = 1'b0; exc_badv = 32'd0;
        cycle(); drive_idle();
        n_checks++;
        if (status[1] !== 1'b1 || int_req !== 1'b0) begin
            n_fail++; $display("FAIL irq_exl status=%h int_req=%b exp EXL=1 int_req=0", status, int_req);
        end
        eret = 1'b1; cycle(); drive_idle();
        n_checks++;
        if (status[1] !== 1'b0 || int_req !== 1'b1) begin
            n_fail++; $display("FAIL irq_eret status=%h int_req=%b exp EXL=0 int_req=1", status, int_req);
        end
        int_in = 6'd0; cycle();
    endtask

    task automatic test_exception();
        exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'hBFC0_0100;
        exc_ds = 1'b1; exc_badv = 32'h1234_5679;
        cycle(); drive_idle();
        raddr = 5'd8; #1;
        n_checks++;
        if (epc !== 32'hBFC0_00FC || cause[31] !== 1'b1 || cause[6:2] !== 5'd4
            || rdata !== 32'h1234_5679 || status[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL exc_first epc=%h cause=%h badv=%h status=%h exp bfc000fc/BD=1,code4/12345679/EXL=1",
                     epc, cause, rdata, status);
        end
    endtask

    task automatic test_nested();
        exc_valid = 1'b1; exc_code = 5'd10; exc_pc = 32'h8000_0000;
        exc_ds = 1'b0; exc_badv = 32'hDEAD_BEEF;
        cycle(); drive_idle();
        raddr = 5'd8; #1;
        n_checks++;
        if (epc !== 32'hBFC0_00FC || cause[31] !== 1'b1 || cause[6:2] !== 5'd10
            || rdata !== 32'h1234_5679) begin
            n_fail++;
            $display("FAIL exc_nested epc=%h cause=%h badv=%h exp bfc000fc/BD=1,code10/12345679",
                     epc, cause, rdata);
        end
        eret = 1'b1; cycle(); drive_idle();
        n_checks++;
        if (status[1] !== 1'b0 || cause[6:2] !== 5'd10) begin
            n_fail++; $display("FAIL exc_eret status=%h cause=%h exp EXL=0 code10", status, cause);
        end
    endtask

    task automatic test_priority();
        we = 1'b1; waddr = 5'd14; wdata = 32'hAAAA_AAAA;
        exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h8000_0020; exc_ds = 1'b0;
        cycle(); drive_idle();
        n_checks++;
        if (epc !== 32'h8000_0020 || cause[31] !== 1'b0) begin
            n_fail++; $display("FAIL prio_epc epc=%h cause=%h exp 80000020 BD=0", epc, cause);
        end
        eret = 1'b1; cycle(); drive_idle();
        // Status write with both exception and ERET: EXL from exception, IM/IE from MTC0.
        we = 1'b1; waddr = 5'd12; wdata = 32'h0000_0301;
        exc_valid = 1'b1; eret = 1'b1; exc_code = 5'd12; exc_pc = 32'h8000_0040;
        cycle(); drive_idle();
        n_checks++;
        if (status !== 32'h0040_0303 || epc !== 32'h8000_0040 || cause[6:2] !== 5'd12) begin
            n_fail++; $display("FAIL prio_status status=%h epc=%h cause=%h exp 00400303/80000040/code12",
                               status, epc, cause);
        end
        eret = 1'b1; cycle(); drive_idle();
    endtask

    task automatic test_count_wrap();
        u1_reset = 1'b1; u1_int = 3'b111;
        u1_we = 1'b1; u1_waddr = 5'd11; u1_wdata = 32'd5; cycle();
        u1_waddr = 5'd9; u1_wdata = 32'd3; cycle(); u1_we = 1'b0;
        n_checks++;
        if (u1_timer !== 1'b0) begin
            n_fail++; $display("FAIL div1_no_match timer=%b exp 0", u1_timer);
        end
        cycle(); cycle();
        u1_raddr = 5'd9; #1;
        n_checks++;
        if (u1_rdata !== 32'd5 || u1_timer !== 1'b1 || u1_cause[30] !== 1'b1
            || u1_cause[15:10] !== 6'b000111) begin
            n_fail++; $display("FAIL div1_match count=%h timer=%b cause=%h exp 5/1/TI=1 IP[15:10]=000111",
                               u1_rdata, u1_timer, u1_cause);
        end
        u1_we = 1'b1; u1_waddr = 5'd9; u1_wdata = 32'hFFFF_FFFF; cycle(); u1_we = 1'b0;
        n_checks++;
        if (u1_rdata !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL div1_write count=%h exp ffffffff", u1_rdata);
        end
        cycle();
        n_checks++;
        if (u1_rdata !== 32'd0) begin
            n_fail++; $display("FAIL div1_wrap count=%h exp 00000000", u1_rdata);
        end
    endtask

    task automatic test_random();
        int sel;
        for (int it = 0; it < 400; it++) begin
            sel = $urandom_range(0, 7);
            we = ($urandom_range(0, 2) == 0);
            case (sel)
                0:       waddr = 5'd8;
                1:       waddr = 5'd9;
                2, 3:    waddr = 5'd11;
                4:       waddr = 5'd12;
                5:       waddr = 5'd13;
                6:       waddr = 5'd14;
                default: waddr = 5'($urandom);
            endcase
            wdata = $urandom;
            if (waddr == 5'd11) wdata = m_count() + 32'($urandom_range(0, 6));
            if (waddr == 5'd9 && $urandom_range(0, 1) == 1)
                wdata = m_compare - 32'($urandom_range(0, 3));
            int_in    = 6'($urandom);
            exc_valid = ($urandom_range(0, 7) == 0);
            exc_code  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(4, 5)) : 5'($urandom);
            exc_pc    = $urandom;
            exc_ds    = 1'($urandom);
            exc_badv  = $urandom;
            eret      = ($urandom_range(0, 7) == 0);
            raddr     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(8, 14));
            #1;
            n_checks++;
            if (rdata !== m_read(raddr)) begin
                n_fail++; $display("FAIL rnd_read it=%0d addr=%0d got=%h exp=%h", it, raddr, rdata, m_read(raddr));
            end
            cycle();
            n_checks++;
            if (status !== m_status()) begin
                n_fail++; $display("FAIL rnd_status it=%0d got=%h exp=%h", it, status, m_status());
            end
            n_checks++;
            if (cause !== m_cause()) begin
                n_fail++; $display("FAIL rnd_cause it=%0d got=%h exp=%h", it, cause, m_cause());
            end
            n_checks++;
            if (epc !== m_epc) begin
                n_fail++; $display("FAIL rnd_epc it=%0d got=%h exp=%h", it, epc, m_epc);
            end
            n_checks++;
            if (timer_int !== m_ti || int_req !== m_intreq()) begin
                n_fail++; $display("FAIL rnd_irq it=%0d timer=%b int_req=%b exp %b/%b",
                                   it, timer_int, int_req, m_ti, m_intreq());
            end
        end
        drive_idle();
    endtask

    initial begin
        reset = 1'b0; u1_reset = 1'b0;
        we = 1'b0; waddr = 5'd0; raddr = 5'd0; wdata = 32'd0; int_in = 6'd0;
        exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'd0; exc_ds = 1'b0;
        exc_badv = 32'd0; eret = 1'b0;
        u1_we = 1'b0; u1_waddr = 5'd0; u1_raddr = 5'd9; u1_wdata = 32'd0; u1_int = 3'd0;
        m_badv = 0; m_cnt_base = 0; m_cnt_cyc = 0; m_compare = 0; m_epc = 0;
        m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_ipsw = 0; m_ipext = 0; m_exc = 0;
        #2;
        test_reset();
        test_timer();
        test_interrupt();
        test_exception();
        test_nested();
        test_priority();
        test_count_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout after %0d checks", n_checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
